// File: rtl/flash_access_sequencer.sv
// Two-port round-robin sequencer for a single flash array port: grants one command at a
// time, drives a timed READ/PROGRAM/ERASE strobe window and returns one-cycle done pulses.
module flash_access_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RD_CYC      = 2,
  parameter int PROG_CYC    = 8,
  parameter int ERASE_CYC   = 64,
  parameter int SECTOR_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic              m1_erase,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              wp,
  output logic              err,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [DATA_W-1:0] flash_wdata,
  input  logic [DATA_W-1:0] flash_rdata,
  output logic              flash_re,
  output logic              flash_we,
  output logic              flash_erase,
  output logic              busy
);

  localparam int MAX_CYC = (ERASE_CYC > PROG_CYC)
                         ? ((ERASE_CYC > RD_CYC) ? ERASE_CYC : RD_CYC)
                         : ((PROG_CYC > RD_CYC) ? PROG_CYC : RD_CYC);
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD    = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] PROG_LOAD  = CNT_W'(PROG_CYC - 1);
  localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(ERASE_CYC - 1);
  localparam logic [ADDR_W-1:0] SECTOR_MASK = ADDR_W'((64'd1 << SECTOR_BITS) - 64'd1);

  typedef enum logic [2:0] {IDLE, READ, PROG, ERASE, DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              port_q;
  logic              last_gnt_q;
  logic              blk_q;
  logic              m0_gnt_q, m1_gnt_q, m0_done_q, m1_done_q, err_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
  logic [ADDR_W-1:0] flash_addr_q;
  logic [DATA_W-1:0] flash_wdata_q;
  logic              flash_re_q, flash_we_q, flash_erase_q;

  // Arbitration and command decode for the port that would be granted this cycle.
  logic              pick1_d;
  logic              erase_d;
  logic              write_d;
  logic              blocked_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  assign pick1_d   = m1_req & (~m0_req | ~last_gnt_q);
  assign erase_d   = pick1_d & m1_erase;
  assign write_d   = pick1_d ? m1_write : m0_write;
  assign blocked_d = wp & (erase_d | write_d);
  assign addr_d    = pick1_d ? m1_addr  : m0_addr;
  assign wdata_d   = pick1_d ? m1_wdata : m0_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      port_q        <= 1'b0;
      last_gnt_q    <= 1'b1;
      blk_q         <= 1'b0;
      m0_gnt_q      <= 1'b0;
      m1_gnt_q      <= 1'b0;
      m0_done_q     <= 1'b0;
      m1_done_q     <= 1'b0;
      err_q         <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
      flash_addr_q  <= '0;
      flash_wdata_q <= '0;
      flash_re_q    <= 1'b0;
      flash_we_q    <= 1'b0;
      flash_erase_q <= 1'b0;
    end else begin
      m0_gnt_q  <= 1'b0;
      m1_gnt_q  <= 1'b0;
      m0_done_q <= 1'b0;
      m1_done_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            port_q        <= pick1_d;
            m0_gnt_q      <= ~pick1_d;
            m1_gnt_q      <= pick1_d;
            flash_addr_q  <= erase_d ? (addr_d & ~SECTOR_MASK) : addr_d;
            flash_wdata_q <= wdata_d;
            if (blocked_d) begin
              state_q <= DONE;
              blk_q   <= 1'b1;
            end else if (erase_d) begin
              state_q       <= ERASE;
              cnt_q         <= ERASE_LOAD;
              flash_erase_q <= 1'b1;
            end else if (write_d) begin
              state_q    <= PROG;
              cnt_q      <= PROG_LOAD;
              flash_we_q <= 1'b1;
            end else begin
              state_q    <= READ;
              cnt_q      <= RD_LOAD;
              flash_re_q <= 1'b1;
            end
          end
        end
        READ, PROG, ERASE: begin
          if (cnt_q == '0) begin
            state_q       <= DONE;
            flash_re_q    <= 1'b0;
            flash_we_q    <= 1'b0;
            flash_erase_q <= 1'b0;
            m0_done_q     <= ~port_q;
            m1_done_q     <= port_q;
            if (state_q == READ) begin
              if (port_q) m1_rdata_q <= flash_rdata;
              else        m0_rdata_q <= flash_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          // A write-protected command skipped its op window, so its completion is reported here.
          state_q    <= IDLE;
          last_gnt_q <= port_q;
          blk_q      <= 1'b0;
          if (blk_q) begin
            m0_done_q <= ~port_q;
            m1_done_q <= port_q;
            err_q     <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_gnt      = m0_gnt_q;
  assign m1_gnt      = m1_gnt_q;
  assign m0_done     = m0_done_q;
  assign m1_done     = m1_done_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign err         = err_q;
  assign flash_addr  = flash_addr_q;
  assign flash_wdata = flash_wdata_q;
  assign flash_re    = flash_re_q;
  assign flash_we    = flash_we_q;
  assign flash_erase = flash_erase_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_flash_access_sequencer.sv
// Directed bench for flash_access_sequencer: a table of single-port commands with
// hand-computed timing, plus abort-by-reset and round-robin tie sequences.
module tb_flash_access_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_write, m0_gnt, m0_done;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_write, m1_erase, m1_gnt, m1_done;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        wp, err;
  logic [31:0] flash_addr, flash_wdata, flash_rdata;
  logic        flash_re, flash_we, flash_erase, busy;

  always #5 clk = ~clk;

  flash_access_sequencer #(
    .ADDR_W(32), .DATA_W(32), .RD_CYC(2), .PROG_CYC(8), .ERASE_CYC(64), .SECTOR_BITS(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_erase(m1_erase), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .wp(wp), .err(err),
    .flash_addr(flash_addr), .flash_wdata(flash_wdata), .flash_rdata(flash_rdata),
    .flash_re(flash_re), .flash_we(flash_we), .flash_erase(flash_erase), .busy(busy)
  );

  typedef struct {
    bit          port;
    bit          wr;
    bit          er;
    bit          wp;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          exp_done;
    int          exp_re;
    int          exp_we;
    int          exp_er;
    bit          exp_err;
    logic [31:0] exp_faddr;
    logic [31:0] exp_m0_rdata;
    logic [31:0] exp_m1_rdata;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input bit port, input bit wr, input bit er, input bit wpv,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                         input int ed, input int ere, input int ewe, input int eer, input bit eerr,
                         input logic [31:0] efa, input logic [31:0] er0, input logic [31:0] er1);
    vecs[i].port = port;  vecs[i].wr = wr;  vecs[i].er = er;  vecs[i].wp = wpv;
    vecs[i].addr = addr;  vecs[i].wdata = wdata;  vecs[i].rdata = rdata;
    vecs[i].exp_done = ed;  vecs[i].exp_re = ere;  vecs[i].exp_we = ewe;  vecs[i].exp_er = eer;
    vecs[i].exp_err = eerr;  vecs[i].exp_faddr = efa;
    vecs[i].exp_m0_rdata = er0;  vecs[i].exp_m1_rdata = er1;
  endtask

  // Issue one command, follow it cycle by cycle (k=1 is the cycle after the sampling edge).
  task automatic run_vec(input vec_t v, input int idx);
    int k, gnt_k, done_k, re_c, we_c, er_c, addr_bad, wd_bad, excl_bad, other_bad;
    logic err_at, busy_after;
    logic [31:0] r0, r1;
    gnt_k = 0; done_k = 0; re_c = 0; we_c = 0; er_c = 0;
    addr_bad = 0; wd_bad = 0; excl_bad = 0; other_bad = 0;
    err_at = 1'b0; r0 = '0; r1 = '0;
    flash_rdata = ~v.rdata;
    wp = v.wp;
    if (!v.port) begin
      m0_write = v.wr; m0_addr = v.addr; m0_wdata = v.wdata; m0_req = 1'b1;
    end else begin
      m1_write = v.wr; m1_erase = v.er; m1_addr = v.addr; m1_wdata = v.wdata; m1_req = 1'b1;
    end
    k = 0;
    while (done_k == 0 && k < 200) begin
      tick;
      k++;
      flash_rdata = flash_re ? v.rdata : ~v.rdata;
      if (v.port ? m1_gnt : m0_gnt) begin
        if (gnt_k == 0) gnt_k = k;
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      if (v.port ? m0_gnt : m1_gnt) other_bad++;
      if (v.port ? m0_done : m1_done) other_bad++;
      re_c += int'(flash_re);
      we_c += int'(flash_we);
      er_c += int'(flash_erase);
      if (int'(flash_re) + int'(flash_we) + int'(flash_erase) > 1) excl_bad++;
      if ((flash_re || flash_we || flash_erase) && flash_addr !== v.exp_faddr) addr_bad++;
      if (flash_we && flash_wdata !== v.wdata) wd_bad++;
      if (v.port ? m1_done : m0_done) begin
        done_k = k; err_at = err; r0 = m0_rdata; r1 = m1_rdata;
      end else if (err) begin
        other_bad++;
      end
    end
    tick;
    busy_after = busy;
    m0_req = 1'b0; m1_req = 1'b0; m0_write = 1'b0; m1_write = 1'b0; m1_erase = 1'b0; wp = 1'b0;
    chk($sformatf("v%0d_gnt_cycle", idx), gnt_k, 1);
    chk($sformatf("v%0d_done_cycle", idx), done_k, v.exp_done);
    chk($sformatf("v%0d_re_cycles", idx), re_c, v.exp_re);
    chk($sformatf("v%0d_we_cycles", idx), we_c, v.exp_we);
    chk($sformatf("v%0d_erase_cycles", idx), er_c, v.exp_er);
    chk($sformatf("v%0d_err", idx), 32'(err_at), 32'(v.exp_err));
    chk($sformatf("v%0d_addr_bad_cycles", idx), addr_bad, 0);
    chk($sformatf("v%0d_wdata_bad_cycles", idx), wd_bad, 0);
    chk($sformatf("v%0d_strobe_overlap", idx), excl_bad, 0);
    chk($sformatf("v%0d_wrong_port_events", idx), other_bad, 0);
    chk($sformatf("v%0d_m0_rdata", idx), r0, v.exp_m0_rdata);
    chk($sformatf("v%0d_m1_rdata", idx), r1, v.exp_m1_rdata);
    chk($sformatf("v%0d_busy_after", idx), 32'(busy_after), 0);
    $display("vec %0d: port %0d wr %0b er %0b wp %0b gnt@%0d done@%0d re=%0d we=%0d erase=%0d err=%0b",
             idx, v.port, v.wr, v.er, v.wp, gnt_k, done_k, re_c, we_c, er_c, err_at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k, gnt_k, cnt, n, both_bad;
    int ord[4];
    int gk[4];
    int exp_ord[4];
    exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 0; exp_ord[3] = 1;

    rst = 1'b1; wp = 1'b0;
    m0_req = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_write = 1'b0; m1_erase = 1'b0; m1_addr = '0; m1_wdata = '0;
    flash_rdata = '0;
    tick; tick;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_strobes", 32'({flash_re, flash_we, flash_erase}), 0);
    chk("reset_gnt_done_err", 32'({m0_gnt, m1_gnt, m0_done, m1_done, err}), 0);
    chk("reset_flash_addr", flash_addr, 0);
    chk("reset_flash_wdata", flash_wdata, 0);
    chk("reset_m0_rdata", m0_rdata, 0);
    chk("reset_m1_rdata", m1_rdata, 0);
    rst = 1'b0;
    tick;

    //      i  p wr er wp addr           wdata          rdata          done re we er  err faddr          m0_rdata       m1_rdata
    set_vec(0, 0, 0, 0, 0, 32'h0000_0100, 32'h0,         32'hCAFE_0001, 3,   2, 0, 0,  0, 32'h0000_0100, 32'hCAFE_0001, 32'h0);
    set_vec(1, 1, 0, 0, 0, 32'h0000_2004, 32'h0,         32'h1234_5678, 3,   2, 0, 0,  0, 32'h0000_2004, 32'hCAFE_0001, 32'h1234_5678);
    set_vec(2, 0, 1, 0, 0, 32'h0000_0040, 32'hA5A5_5A5A, 32'hDEAD_BEEF, 9,   0, 8, 0,  0, 32'h0000_0040, 32'hCAFE_0001, 32'h1234_5678);
    set_vec(3, 1, 1, 1, 0, 32'h0000_1234, 32'hFFFF_FFFF, 32'h0,         65,  0, 0, 64, 0, 32'h0000_1200, 32'hCAFE_0001, 32'h1234_5678);
    set_vec(4, 0, 1, 0, 1, 32'h0000_0080, 32'h1111_1111, 32'h0,         2,   0, 0, 0,  1, 32'h0,         32'hCAFE_0001, 32'h1234_5678);
    set_vec(5, 1, 0, 1, 1, 32'h0000_5678, 32'h0,         32'h0,         2,   0, 0, 0,  1, 32'h0,         32'hCAFE_0001, 32'h1234_5678);
    set_vec(6, 1, 1, 0, 0, 32'hFFFF_FFFC, 32'h0BAD_F00D, 32'h0,         9,   0, 8, 0,  0, 32'hFFFF_FFFC, 32'hCAFE_0001, 32'h1234_5678);
    set_vec(7, 0, 0, 0, 1, 32'h0000_0200, 32'h0,         32'h5555_AAAA, 3,   2, 0, 0,  0, 32'h0000_0200, 32'h5555_AAAA, 32'h1234_5678);
    set_vec(8, 1, 0, 1, 0, 32'hFFFF_FFFF, 32'h0,         32'h0,         65,  0, 0, 64, 0, 32'hFFFF_FF00, 32'h5555_AAAA, 32'h1234_5678);
    set_vec(9, 0, 0, 0, 0, 32'h0000_0008, 32'h0,         32'h0F0F_0F0F, 3,   2, 0, 0,  0, 32'h0000_0008, 32'h0F0F_0F0F, 32'h1234_5678);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Port 0 was granted last, so only a reset can make port 0 win the next tie.
    m0_write = 1'b1; m0_addr = 32'h0000_0300; m0_wdata = 32'hA5A5_5A5A; m0_req = 1'b1;
    k = 0; gnt_k = 0;
    while (k < 20 && gnt_k == 0) begin
      tick; k++;
      if (m0_gnt) gnt_k = k;
    end
    m0_req = 1'b0; m0_write = 1'b0;
    chk("abort_gnt_cycle", gnt_k, 1);
    tick; tick;
    chk("abort_we_in_prog_cycle3", 32'(flash_we), 1);
    rst = 1'b1;
    tick;
    chk("abort_we_after_rst", 32'(flash_we), 0);
    chk("abort_busy_after_rst", 32'(busy), 0);
    chk("abort_done_after_rst", 32'({m0_done, m1_done}), 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      cnt += int'(m0_done) + int'(m1_done) + int'(flash_we) + int'(busy);
    end
    chk("abort_quiet_after_rst", cnt, 0);
    $display("abort: gnt@%0d, reset in PROG cycle 3, quiet events after reset=%0d", gnt_k, cnt);

    // Both ports keep requesting reads; grants must alternate starting with port 0.
    m0_write = 1'b0; m0_addr = 32'h0000_0010;
    m1_write = 1'b0; m1_erase = 1'b0; m1_addr = 32'h0000_0020;
    m0_req = 1'b1; m1_req = 1'b1;
    n = 0; both_bad = 0; k = 0;
    for (int i = 0; i < 4; i++) begin ord[i] = -1; gk[i] = 0; end
    while (n < 4 && k < 60) begin
      tick; k++;
      if (m0_gnt && m1_gnt) both_bad++;
      if (m0_gnt || m1_gnt) begin
        ord[n] = int'(m1_gnt);
        gk[n] = k;
        n++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("rr_grant_count", n, 4);
    chk("rr_both_gnt_cycles", both_bad, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order_%0d", i), ord[i], exp_ord[i]);
    for (int i = 1; i < 4; i++) chk($sformatf("rr_spacing_%0d", i), gk[i] - gk[i-1], 4);
    $display("rr: grants %0d %0d %0d %0d at cycles %0d %0d %0d %0d", ord[0], ord[1], ord[2], ord[3],
             gk[0], gk[1], gk[2], gk[3]);
    k = 0;
    while (busy && k < 20) begin tick; k++; end
    chk("rr_idle_after", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
